// File: rtl/fireplace_sequencer.sv
// Timed fireplace burner sequencer: ignition with retries, flame-proven heat with
// hysteresis, delayed fan, post-burn purge and a safety lockout.
module fireplace_sequencer #(
   parameter int HYST        = 1,
   parameter int IGN_TICKS   = 3,
   parameter int MAX_RETRY   = 3,
   parameter int FAN_TEMP    = 15,
   parameter int FAN_DELAY   = 2,
   parameter int PURGE_TICKS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       power,
   input  logic [4:0] S,
   input  logic [4:0] T,
   input  logic       flame,
   output logic       igniter,
   output logic       fireplace,
   output logic       fan,
   output logic       fault,
   output logic [2:0] state
);

   localparam int CMAX = (IGN_TICKS > PURGE_TICKS) ? IGN_TICKS : PURGE_TICKS;
   localparam int CW   = $clog2(CMAX + 2);
   localparam int RW   = $clog2(MAX_RETRY + 2);
   localparam int FW   = $clog2(FAN_DELAY + 2);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      IGNITE  = 3'd1,
      HEAT    = 3'd2,
      PURGE   = 3'd3,
      LOCKOUT = 3'd4
   } state_t;

   state_t          state_q, state_n;
   logic [CW-1:0]   cnt_q, cnt_n, cnt_inc;
   logic [RW-1:0]   retry_q, retry_n, retry_inc;
   logic [FW-1:0]   fan_cnt_q, fan_cnt_n;
   logic            fan_q, fan_n;
   logic            call_on, call_off;

   // Six-bit compare so T + HYST never wraps back below S.
   assign call_on   = power && (S < T);
   assign call_off  = !power || ({1'b0, S} >= (6'({1'b0, T}) + 6'(HYST)));
   assign cnt_inc   = cnt_q + 1'b1;
   assign retry_inc = retry_q + 1'b1;

   always_comb begin
      state_n   = state_q;
      cnt_n     = cnt_q;
      retry_n   = retry_q;
      fan_cnt_n = fan_cnt_q;
      case (state_q)
         IDLE: begin
            if (call_on) begin
               state_n = IGNITE;
               cnt_n   = '0;
               retry_n = '0;
            end
         end
         IGNITE: begin
            if (!power) begin
               state_n = PURGE;
               cnt_n   = '0;
            end else if (tick) begin
               if (cnt_inc == CW'(IGN_TICKS)) begin
                  cnt_n = '0;
                  if (flame) begin
                     state_n   = HEAT;
                     retry_n   = '0;
                     fan_cnt_n = '0;
                  end else if (retry_inc < RW'(MAX_RETRY)) begin
                     retry_n = retry_inc;
                  end else begin
                     state_n = LOCKOUT;
                  end
               end else begin
                  cnt_n = cnt_inc;
               end
            end
         end
         HEAT: begin
            if (call_off) begin
               state_n = PURGE;
               cnt_n   = '0;
            end else if (!flame) begin
               state_n = IGNITE;
               cnt_n   = '0;
               retry_n = '0;
            end else if (tick && fan_cnt_q != FW'(FAN_DELAY)) begin
               fan_cnt_n = fan_cnt_q + 1'b1;
            end
         end
         PURGE: begin
            if (tick) begin
               if (cnt_inc == CW'(PURGE_TICKS)) begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
         end
         LOCKOUT: begin
            if (!power) begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
      // Fan is registered from the state/counter we are moving into.
      fan_n = (state_n == PURGE) ||
              (state_n == HEAT && fan_cnt_n == FW'(FAN_DELAY) && S > 5'(FAN_TEMP));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         retry_q   <= '0;
         fan_cnt_q <= '0;
         fan_q     <= 1'b0;
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         retry_q   <= retry_n;
         fan_cnt_q <= fan_cnt_n;
         fan_q     <= fan_n;
      end
   end

   assign igniter   = (state_q == IGNITE);
   assign fireplace = (state_q == IGNITE) || (state_q == HEAT);
   assign fault     = (state_q == LOCKOUT);
   assign fan       = fan_q;
   assign state     = state_q;

endmodule

// File: tb/tb_fireplace_sequencer.sv
// Directed bench for fireplace_sequencer: expected output words are queued as each
// cycle's stimulus is driven and checked just after the clock edge.
module tb_fireplace_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic       power = 1'b0;
   logic [4:0] S = 5'd0;
   logic [4:0] T = 5'd0;
   logic       flame = 1'b0;
   logic       igniter, fireplace, fan, fault;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;
   logic [6:0] exp_q[$];

   localparam logic [2:0] ST_IDLE = 3'd0, ST_IGN = 3'd1, ST_HEAT = 3'd2,
                          ST_PURGE = 3'd3, ST_LOCK = 3'd4;

   fireplace_sequencer dut (
      .clk(clk), .reset(reset), .tick(tick), .power(power), .S(S), .T(T),
      .flame(flame), .igniter(igniter), .fireplace(fireplace), .fan(fan),
      .fault(fault), .state(state)
   );

   always #5 clk = ~clk;

   // Output word {state, igniter, fireplace, fan, fault}; Moore bits follow the state.
   function automatic logic [6:0] ex(input logic [2:0] st, input logic f);
      ex = {st, st == ST_IGN, (st == ST_IGN) || (st == ST_HEAT), f, st == ST_LOCK};
   endfunction

   task automatic check(input string tag, input logic [6:0] got, input logic [6:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%b want=%b (state,ign,valve,fan,fault)", tag, got, want);
      end
   endtask

   task automatic cyc(input string tag, input logic tk, input logic [2:0] st, input logic f);
      logic [6:0] want;
      tick = tk;
      exp_q.push_back(ex(st, f));
      @(posedge clk);
      #1;
      tick = 1'b0;
      want = exp_q.pop_front();
      check(tag, {state, igniter, fireplace, fan, fault}, want);
   endtask

   initial begin
      // Reset
      reset = 1'b1;
      cyc("reset0", 0, ST_IDLE, 0);
      cyc("reset1", 1, ST_IDLE, 0);
      reset = 1'b0;

      // Normal heat: ignite, three ticks, HEAT on the third tick
      power = 1; S = 10; T = 20; flame = 1;
      cyc("ign_enter", 0, ST_IGN, 0);
      cyc("ign_t1", 1, ST_IGN, 0);
      cyc("ign_idle", 0, ST_IGN, 0);
      cyc("ign_t2", 1, ST_IGN, 0);
      cyc("heat_enter", 1, ST_HEAT, 0);

      // Fan gating; the entry tick must not have counted toward the delay
      S = 16;
      cyc("fan_d1", 1, ST_HEAT, 0);
      cyc("fan_d1b", 0, ST_HEAT, 0);
      cyc("fan_on", 1, ST_HEAT, 1);
      S = 15;
      cyc("fan_s15", 0, ST_HEAT, 0);
      for (int i = 0; i < 3; i++) cyc("fan_s15_hold", 1, ST_HEAT, 0);

      // Hysteresis and purge, demand ignored in PURGE
      S = 20;
      cyc("hyst_s20", 1, ST_HEAT, 1);
      S = 21;
      cyc("purge_enter", 0, ST_PURGE, 1);
      S = 10;
      for (int i = 0; i < 3; i++) cyc("purge_hold", 1, ST_PURGE, 1);
      cyc("purge_nontick", 0, ST_PURGE, 1);
      cyc("purge_done", 1, ST_IDLE, 0);

      // Lockout after three failed attempts
      flame = 0;
      cyc("lk_ign", 0, ST_IGN, 0);
      for (int i = 0; i < 8; i++) cyc("lk_retry", 1, ST_IGN, 0);
      cyc("lk_enter", 1, ST_LOCK, 0);
      for (int i = 0; i < 3; i++) cyc("lk_hold", 1, ST_LOCK, 0);
      power = 0;
      cyc("lk_exit", 0, ST_IDLE, 0);
      cyc("idle_off", 1, ST_IDLE, 0);

      // Flame loss in HEAT, then power drop mid-IGNITE
      power = 1; flame = 1;
      cyc("fl_ign", 0, ST_IGN, 0);
      for (int i = 0; i < 2; i++) cyc("fl_ign_t", 1, ST_IGN, 0);
      cyc("fl_heat", 1, ST_HEAT, 0);
      flame = 0;
      cyc("fl_lost", 0, ST_IGN, 0);
      // Fresh retry count: two failed attempts must not lock out
      for (int i = 0; i < 6; i++) cyc("fl_retry", 1, ST_IGN, 0);
      power = 0;
      cyc("pwr_drop", 1, ST_PURGE, 1);
      for (int i = 0; i < 3; i++) cyc("pwr_purge", 1, ST_PURGE, 1);
      cyc("pwr_idle", 1, ST_IDLE, 0);

      // T=31, S=31: no temperature-driven exit
      power = 1; flame = 1; S = 10; T = 31;
      cyc("b_ign", 0, ST_IGN, 0);
      for (int i = 0; i < 2; i++) cyc("b_ign_t", 1, ST_IGN, 0);
      cyc("b_heat", 1, ST_HEAT, 0);
      S = 31;
      cyc("b_s31_1", 1, ST_HEAT, 0);
      cyc("b_s31_2", 1, ST_HEAT, 1);
      for (int i = 0; i < 3; i++) cyc("b_s31_hold", 1, ST_HEAT, 1);

      // Reset mid-HEAT
      reset = 1;
      cyc("rst_heat", 1, ST_IDLE, 0);
      reset = 0; power = 0;
      cyc("rst_after", 0, ST_IDLE, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
